// File: rtl/puzzle_move_player_pkg.sv
// Shared types and constants for the sliding-puzzle move player.
package puzzle_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } player_state_t;

  localparam int         GRID    = 3;
  localparam logic [1:0] START_X = 2'd0;
  localparam logic [1:0] START_Y = 2'd2;
  localparam logic [1:0] POS_MAX = 2'(GRID - 1);

  // A move is legal when the empty cell stays on the grid afterwards.
  function automatic logic move_legal(input dir_t d, input logic [1:0] x, input logic [1:0] y);
    logic ok;
    ok = 1'b0;
    case (d)
      DIR_LEFT:  ok = (y != 2'd0);
      DIR_RIGHT: ok = (y < POS_MAX);
      DIR_UP:    ok = (x != 2'd0);
      DIR_DOWN:  ok = (x < POS_MAX);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/puzzle_move_player_fifo.sv
// Move buffer: DEPTH x 2-bit FIFO, synchronous push/pop, registered fill.
// The head entry is read combinationally so the player can judge it in the
// same cycle it is popped.
module move_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [1:0]               wdata,
  output logic [1:0]               rdata,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

  logic [1:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [FILL_W-1:0] r_fill;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = push && (r_fill < FULL_LVL);
  assign w_do_pop  = pop && (r_fill != '0);
  assign rdata     = r_mem[r_rd_ptr];
  assign fill      = r_fill;

  // Storage array; contents are don't-care once pointers are flushed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/puzzle_move_player.sv
// Buffers a move script, then replays it one move per cycle to the puzzle
// core, suppressing moves that would push the empty cell off the grid.
//
// state | meaning
// IDLE  | accepting moves, waiting for start
// PLAY  | popping one move per cycle, pushes refused
// DONE  | script exhausted, done sticky until the next push
module puzzle_move_player #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [1:0]             in_dir,
  output logic                   in_ready,
  input  logic                   start,
  output logic                   dir_valid,
  output logic [1:0]             direction,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fill,
  output logic [CNT_W-1:0]       move_count,
  output logic [CNT_W-1:0]       illegal_count
);
  import puzzle_pkg::*;

  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

  player_state_t     r_state;
  player_state_t     w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_fifo_rdata;
  dir_t              w_head;
  logic [FILL_W-1:0] w_fill;
  logic              w_legal;
  logic [1:0]        r_ex;
  logic [1:0]        r_ey;
  logic [1:0]        w_ex_nxt;
  logic [1:0]        w_ey_nxt;
  logic              r_dir_valid;
  logic [1:0]        r_direction;
  logic [CNT_W-1:0]  r_move_count;
  logic [CNT_W-1:0]  r_illegal_count;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_dir),
    .rdata (w_fifo_rdata),
    .fill  (w_fill)
  );

  assign w_head        = dir_t'(w_fifo_rdata);
  assign fill          = w_fill;
  assign dir_valid     = r_dir_valid;
  assign direction     = r_direction;
  assign move_count    = r_move_count;
  assign illegal_count = r_illegal_count;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state; IDLE decides on pre-push fill, a push in DONE takes priority.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = (w_fill != '0) ? PLAY : DONE;
      PLAY: if (w_fill <= FILL_W'(1)) w_state_nxt = DONE;
      DONE: begin
        if (w_push)                      w_state_nxt = IDLE;
        else if (start && w_fill != '0) w_state_nxt = PLAY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    w_pop    = 1'b0;
    case (r_state)
      IDLE: in_ready = (w_fill < FULL_LVL);
      PLAY: begin
        busy  = 1'b1;
        w_pop = (w_fill != '0);
      end
      DONE: begin
        done     = 1'b1;
        in_ready = (w_fill < FULL_LVL);
      end
      default: ;
    endcase
    w_push = in_valid && in_ready;
  end

  // Legality of the head move and where the empty cell would go.
  always_comb begin
    w_legal  = move_legal(w_head, r_ex, r_ey);
    w_ex_nxt = r_ex;
    w_ey_nxt = r_ey;
    case (w_head)
      DIR_LEFT:  w_ey_nxt = r_ey - 2'd1;
      DIR_RIGHT: w_ey_nxt = r_ey + 2'd1;
      DIR_UP:    w_ex_nxt = r_ex - 2'd1;
      DIR_DOWN:  w_ex_nxt = r_ex + 2'd1;
      default: ;
    endcase
  end

  // Registered move output, empty-cell mirror and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dir_valid     <= 1'b0;
      r_direction     <= 2'b00;
      r_ex            <= START_X;
      r_ey            <= START_Y;
      r_move_count    <= '0;
      r_illegal_count <= '0;
    end else if (w_pop) begin
      if (w_legal) begin
        r_dir_valid <= 1'b1;
        r_direction <= w_head;
        r_ex        <= w_ex_nxt;
        r_ey        <= w_ey_nxt;
        if (r_move_count != {CNT_W{1'b1}}) r_move_count <= r_move_count + CNT_W'(1);
      end else begin
        r_dir_valid <= 1'b0;
        if (r_illegal_count != {CNT_W{1'b1}}) r_illegal_count <= r_illegal_count + CNT_W'(1);
      end
    end else begin
      r_dir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puzzle_move_player.sv
// Randomized bench for puzzle_move_player with a queue-based reference model.
module tb_puzzle_move_player;

  localparam int DEPTH  = 32;
  localparam int CNT_W  = 6;
  localparam int FILL_W = 6;
  localparam int GRID   = 3;
  localparam int CMAX   = 63;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        in_dir = 2'b00;
  logic              start = 1'b0;
  logic              in_ready;
  logic              dir_valid;
  logic [1:0]        direction;
  logic              busy;
  logic              done;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  move_count;
  logic [CNT_W-1:0]  illegal_count;

  int checks = 0;
  int errors = 0;

  // Reference model: pending script plus empty-cell coordinates and tallies.
  int m_q[$];
  int m_ex, m_ey, m_mc, m_ic, m_last;

  puzzle_move_player #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_dir        (in_dir),
    .in_ready      (in_ready),
    .start         (start),
    .dir_valid     (dir_valid),
    .direction     (direction),
    .busy          (busy),
    .done          (done),
    .fill          (fill),
    .move_count    (move_count),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_q.delete();
    m_ex = 0; m_ey = 2; m_mc = 0; m_ic = 0; m_last = 0;
  endtask

  task automatic do_reset;
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    tick;
    rst = 1'b1;
    model_reset;
  endtask

  task automatic push_one(input int d);
    bit exp_rdy;
    logic [FILL_W-1:0] efill;
    exp_rdy = (m_q.size() < DEPTH);
    in_valid = 1'b1;
    in_dir = 2'(d);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++; $display("FAIL push_in_ready got %b exp %b", in_ready, exp_rdy);
    end
    tick;
    in_valid = 1'b0;
    if (exp_rdy) m_q.push_back(d);
    efill = FILL_W'(m_q.size());
    checks++;
    if (fill !== efill) begin
      errors++; $display("FAIL push_fill got %0d exp %0d", fill, efill);
    end
  endtask

  // Start a replay of everything in the model queue and check every cycle.
  task automatic run_replay(input bit junk);
    int n;
    int ev[$];
    int ed[$];
    logic [FILL_W-1:0] efill;
    logic [1:0] edir;
    logic evld;
    logic [CNT_W-1:0] emc, eic;
    n = m_q.size();
    for (int i = 0; i < n; i++) begin
      int d, nx, ny;
      d = m_q[i]; nx = m_ex; ny = m_ey;
      case (d)
        0: ny = ny - 1;
        1: ny = ny + 1;
        2: nx = nx - 1;
        default: nx = nx + 1;
      endcase
      if (nx >= 0 && nx < GRID && ny >= 0 && ny < GRID) begin
        m_ex = nx; m_ey = ny; m_last = d;
        if (m_mc < CMAX) m_mc++;
        ev.push_back(1);
      end else begin
        if (m_ic < CMAX) m_ic++;
        ev.push_back(0);
      end
      ed.push_back(m_last);
    end
    m_q.delete();

    start = 1'b1;
    tick;
    start = 1'b0;
    if (junk) begin in_valid = 1'b1; in_dir = 2'b00; end
    for (int i = 0; i < n; i++) begin
      efill = FILL_W'(n - i);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL play_busy got %b exp 1", busy); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL play_in_ready got %b exp 0", in_ready); end
      checks++;
      if (fill !== efill) begin errors++; $display("FAIL play_fill got %0d exp %0d", fill, efill); end
      tick;
      evld = (ev[i] != 0);
      edir = 2'(ed[i]);
      checks++;
      if (dir_valid !== evld) begin
        errors++; $display("FAIL move_valid idx %0d got %b exp %b", i, dir_valid, evld);
      end
      checks++;
      if (direction !== edir) begin
        errors++; $display("FAIL move_dir idx %0d got %0d exp %0d", i, direction, edir);
      end
    end
    if (junk) in_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_set got %b exp 1", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got %b exp 0", busy); end
    checks++;
    if (fill !== '0) begin errors++; $display("FAIL done_fill got %0d exp 0", fill); end
    tick;
    emc = CNT_W'(m_mc);
    eic = CNT_W'(m_ic);
    checks++;
    if (dir_valid !== 1'b0) begin errors++; $display("FAIL after_valid got %b exp 0", dir_valid); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_sticky got %b exp 1", done); end
    checks++;
    if (move_count !== emc) begin errors++; $display("FAIL move_count got %0d exp %0d", move_count, emc); end
    checks++;
    if (illegal_count !== eic) begin errors++; $display("FAIL illegal_count got %0d exp %0d", illegal_count, eic); end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (fill !== '0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill); end
    checks++; if (dir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", dir_valid); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL rst_dir got %0d exp 0", direction); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (move_count !== '0) begin errors++; $display("FAIL rst_mc got %0d exp 0", move_count); end
    checks++; if (illegal_count !== '0) begin errors++; $display("FAIL rst_ic got %0d exp 0", illegal_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic;
    do_reset;
    push_one(0); push_one(3); push_one(1);
    run_replay(1'b0);
    checks++; if (move_count !== 6'd3) begin errors++; $display("FAIL basic_mc got %0d exp 3", move_count); end
    checks++; if (illegal_count !== 6'd0) begin errors++; $display("FAIL basic_ic got %0d exp 0", illegal_count); end
  endtask

  task automatic test_illegal;
    do_reset;
    push_one(1); push_one(2); push_one(0);
    run_replay(1'b0);
    checks++; if (move_count !== 6'd1) begin errors++; $display("FAIL illegal_mc got %0d exp 1", move_count); end
    checks++; if (illegal_count !== 6'd2) begin errors++; $display("FAIL illegal_ic got %0d exp 2", illegal_count); end
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 0; i < DEPTH + 1; i++) push_one(int'($urandom_range(0, 3)));
    checks++; if (fill !== 6'd32) begin errors++; $display("FAIL full_fill got %0d exp 32", fill); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    run_replay(1'b0);
  endtask

  task automatic test_empty;
    do_reset;
    run_replay(1'b0);
    run_replay(1'b0);
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 5; i++) push_one(int'($urandom_range(0, 3)));
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    model_reset;
    checks++; if (fill !== '0) begin errors++; $display("FAIL abort_fill got %0d exp 0", fill); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    checks++; if (dir_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", dir_valid); end
    checks++; if (move_count !== '0) begin errors++; $display("FAIL abort_mc got %0d exp 0", move_count); end
    checks++; if (illegal_count !== '0) begin errors++; $display("FAIL abort_ic got %0d exp 0", illegal_count); end
    push_one(1); push_one(0);
    run_replay(1'b0);
  endtask

  task automatic test_push_during_play;
    do_reset;
    for (int i = 0; i < 4; i++) push_one(int'($urandom_range(0, 3)));
    run_replay(1'b1);
    push_one(0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL repush_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repush_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL repush_in_ready got %b exp 1", in_ready); end
    run_replay(1'b0);
  endtask

  task automatic test_start_with_push;
    do_reset;
    start = 1'b1; in_valid = 1'b1; in_dir = 2'b11;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sp_in_ready got %b exp 1", in_ready); end
    tick;
    start = 1'b0; in_valid = 1'b0;
    m_q.push_back(3);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sp_done got %b exp 1", done); end
    checks++; if (fill !== 6'd1) begin errors++; $display("FAIL sp_fill got %0d exp 1", fill); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_busy got %b exp 0", busy); end
    run_replay(1'b0);
  endtask

  task automatic test_random;
    do_reset;
    for (int it = 0; it < 10; it++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) push_one(int'($urandom_range(0, 3)));
      run_replay(it[0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_illegal;
    test_full;
    test_empty;
    test_reset_mid;
    test_push_during_play;
    test_start_with_push;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
